// File: rtl/id_alu_decode_if.sv
// Fetch/decode/execute handshake plus the decoded bundle handed to the ALU stage.
// master = fetch/execute side, slave = the decode stage.
interface id_alu_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  alu_op;
  logic [1:0]  a_sel;
  logic [1:0]  b_sel;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, alu_op, a_sel, b_sel, imm,
           rs1, rs2, rd, reg_write, mem_read, mem_write, branch, illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, alu_op, a_sel, b_sel, imm,
           rs1, rs2, rd, reg_write, mem_read, mem_write, branch, illegal
  );
endinterface

// File: rtl/id_alu_decode.sv
// Registered RV32I decode stage producing ALU control, operand selects and immediate.
// Optional macro ALU_DEC_SKID_EN adds a one-entry skid buffer with a registered in_ready.
module id_alu_decode #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_OUT = '0
) (
  input  logic            clk,
  input  logic            rst,
  id_alu_decode_if.slave  bus
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  localparam logic [1:0] A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2;
  localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_op;
    logic [1:0]      a_sel;
    logic [1:0]      b_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            illegal;
  } bundle_t;

  localparam int      BW        = $bits(bundle_t);
  localparam bundle_t RST_BUNDLE = bundle_t'({RESET_PC_OUT, {(BW-XLEN){1'b0}}});

  logic [31:0] w_ins;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;
  logic        w_legal;
  bundle_t     w_dec;

  assign w_ins   = bus.in_instr;
  assign w_opc   = w_ins[6:0];
  assign w_f3    = w_ins[14:12];
  assign w_f7    = w_ins[31:25];
  assign w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
  assign w_imm_s = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
  assign w_imm_b = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_imm_u = {w_ins[31:12], 12'b0};
  assign w_imm_j = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
  assign w_shamt = {27'b0, w_ins[24:20]};

  always_comb begin
    w_dec     = '0;
    w_legal   = 1'b1;
    w_dec.pc  = bus.in_pc;
    w_dec.rs1 = w_ins[19:15];
    w_dec.rs2 = w_ins[24:20];
    w_dec.rd  = w_ins[11:7];
    case (w_opc)
      OPC_OP: begin
        w_dec.alu_op    = {w_f7[5], w_f3};
        w_dec.reg_write = 1'b1;
        w_legal = (w_f7 == 7'h00) ||
                  (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101));
      end
      OPC_OPIMM: begin
        w_dec.b_sel     = B_IMM;
        w_dec.reg_write = 1'b1;
        w_dec.alu_op    = {1'b0, w_f3};
        w_dec.imm       = w_imm_i;
        // shifts carry a 5-bit shamt; funct7 selects logical vs arithmetic right
        if (w_f3 == 3'b001) begin
          w_dec.imm = w_shamt;
          w_legal   = (w_f7 == 7'h00);
        end else if (w_f3 == 3'b101) begin
          w_dec.imm    = w_shamt;
          w_dec.alu_op = {w_f7[5], 3'b101};
          w_legal      = (w_f7 == 7'h00) || (w_f7 == 7'h20);
        end
      end
      OPC_LUI: begin
        w_dec.a_sel = A_ZERO; w_dec.b_sel = B_IMM; w_dec.imm = w_imm_u;
        w_dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.a_sel = A_PC; w_dec.b_sel = B_IMM; w_dec.imm = w_imm_u;
        w_dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        w_dec.a_sel = A_PC; w_dec.b_sel = B_FOUR; w_dec.imm = w_imm_j;
        w_dec.reg_write = 1'b1; w_dec.branch = 1'b1;
      end
      OPC_JALR: begin
        w_dec.a_sel = A_PC; w_dec.b_sel = B_FOUR; w_dec.imm = w_imm_i;
        w_dec.reg_write = 1'b1; w_dec.branch = 1'b1;
        w_legal = (w_f3 == 3'b000);
      end
      OPC_LOAD: begin
        w_dec.b_sel = B_IMM; w_dec.imm = w_imm_i;
        w_dec.mem_read = 1'b1; w_dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        w_dec.b_sel = B_IMM; w_dec.imm = w_imm_s;
        w_dec.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.imm = w_imm_b; w_dec.branch = 1'b1;
        case (w_f3[2:1])
          2'b00:   w_dec.alu_op = ALU_SUB;
          2'b10:   w_dec.alu_op = ALU_SLT;
          2'b11:   w_dec.alu_op = ALU_SLTU;
          default: w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
    // illegal encodings keep the register fields but carry no side effects
    if (!w_legal) begin
      w_dec.alu_op    = ALU_ADD;
      w_dec.a_sel     = A_RS1;
      w_dec.b_sel     = B_RS2;
      w_dec.imm       = '0;
      w_dec.reg_write = 1'b0;
      w_dec.mem_read  = 1'b0;
      w_dec.mem_write = 1'b0;
      w_dec.branch    = 1'b0;
      w_dec.illegal   = 1'b1;
    end
  end

  bundle_t r_out;
  logic    r_out_valid;
  logic    w_in_ready;
  logic    w_acc;
  logic    w_out_free;

  assign w_acc      = bus.in_valid && w_in_ready;
  assign w_out_free = !r_out_valid || bus.out_ready;

`ifdef ALU_DEC_SKID_EN
  bundle_t r_skid;
  logic    r_skid_valid;

  // skid can only fill while stalled, and never accepts while full
  assign w_in_ready = !r_skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out        <= RST_BUNDLE;
      r_out_valid  <= 1'b0;
      r_skid       <= RST_BUNDLE;
      r_skid_valid <= 1'b0;
    end else if (bus.flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_acc) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end
`else
  assign w_in_ready = w_out_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= RST_BUNDLE;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_acc) begin
      r_out       <= w_dec;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_pc    = r_out.pc;
  assign bus.alu_op    = r_out.alu_op;
  assign bus.a_sel     = r_out.a_sel;
  assign bus.b_sel     = r_out.b_sel;
  assign bus.imm       = r_out.imm;
  assign bus.rs1       = r_out.rs1;
  assign bus.rs2       = r_out.rs2;
  assign bus.rd        = r_out.rd;
  assign bus.reg_write = r_out.reg_write;
  assign bus.mem_read  = r_out.mem_read;
  assign bus.mem_write = r_out.mem_write;
  assign bus.branch    = r_out.branch;
  assign bus.illegal   = r_out.illegal;
endmodule

// File: tb/tb_id_alu_decode.sv
// Bench for id_alu_decode: directed vector table, handshake corner sequences,
// then random traffic scored against a queue-based reference model.
module tb_id_alu_decode;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_alu_decode_if bus();
  id_alu_decode #(.XLEN(32), .RESET_PC_OUT(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, br, ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [31:0] imm;
    logic [4:0]  flags;  // {reg_write, mem_read, mem_write, branch, illegal}
  } vec_t;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, SLL = 4'b0001, SLT = 4'b0010,
                         SLTU = 4'b0011, XOR = 4'b0100, SRL = 4'b0101, SRA = 4'b1101,
                         OR = 4'b0110, AND = 4'b0111;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t got();
    exp_t g;
    g = {bus.out_pc, bus.imm, bus.alu_op, bus.a_sel, bus.b_sel, bus.rs1, bus.rs2, bus.rd,
         bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.illegal};
    return g;
  endfunction

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    bit ok;
    logic [3:0] base_op [8];
    logic [6:0] op, f7;
    logic [2:0] f3;
    base_op = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    e = '0; ok = 1;
    e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    case (op)
      7'h33: begin
        e.rw = 1;
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.alu = (f7 == 7'h20) ? ((f3 == 0) ? SUB : SRA) : base_op[f3];
      end
      7'h13: begin
        e.rw = 1; e.b = 1;
        if (f3 == 1 || f3 == 5) begin
          e.imm = 32'(ins[24:20]);
          ok = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
          e.alu = (f3 == 5 && f7 == 7'h20) ? SRA : base_op[f3];
        end else begin
          e.imm = 32'($signed(ins[31:20]));
          e.alu = base_op[f3];
        end
      end
      7'h37: begin e.rw = 1; e.a = 2; e.b = 1; e.imm = ins & 32'hFFFF_F000; end
      7'h17: begin e.rw = 1; e.a = 1; e.b = 1; e.imm = ins & 32'hFFFF_F000; end
      7'h6F: begin
        e.rw = 1; e.br = 1; e.a = 1; e.b = 2;
        e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'h67: begin
        e.rw = 1; e.br = 1; e.a = 1; e.b = 2;
        e.imm = 32'($signed(ins[31:20])); ok = (f3 == 0);
      end
      7'h03: begin e.rw = 1; e.mr = 1; e.b = 1; e.imm = 32'($signed(ins[31:20])); end
      7'h23: begin e.mw = 1; e.b = 1; e.imm = 32'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin
        e.br = 1;
        e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        if (f3 == 0 || f3 == 1) e.alu = SUB;
        else if (f3 == 4 || f3 == 5) e.alu = SLT;
        else if (f3 == 6 || f3 == 7) e.alu = SLTU;
        else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      e.alu = ADD; e.a = 0; e.b = 0; e.imm = 0;
      e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.ill = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [9];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 8)];
    case ($urandom_range(0, 2))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic xfer(input logic [31:0] ins, input logic [31:0] pc);
    @(negedge clk);
    bus.in_valid = 1; bus.in_instr = ins; bus.in_pc = pc; bus.out_ready = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
  endtask

  vec_t vecs [10];
  exp_t q [$];
  logic exp_rdy;

  initial begin
    vecs[0] = '{32'h002081B3, ADD,  2'd0, 2'd0, 32'h0,        5'b10000};  // add x3,x1,x2
    vecs[1] = '{32'h407302B3, SUB,  2'd0, 2'd0, 32'h0,        5'b10000};  // sub x5,x6,x7
    vecs[2] = '{32'h40315093, SRA,  2'd0, 2'd1, 32'h3,        5'b10000};  // srai x1,x2,3
    vecs[3] = '{32'h123450B7, ADD,  2'd2, 2'd1, 32'h12345000, 5'b10000};  // lui
    vecs[4] = '{32'h0020E463, SLTU, 2'd0, 2'd0, 32'h8,        5'b00010};  // bltu +8
    vecs[5] = '{32'h00000000, ADD,  2'd0, 2'd0, 32'h0,        5'b00001};  // illegal
    vecs[6] = '{32'hFFC12283, ADD,  2'd0, 2'd1, 32'hFFFFFFFC, 5'b11000};  // lw x5,-4(x2)
    vecs[7] = '{32'h010000EF, ADD,  2'd1, 2'd2, 32'h10,       5'b10010};  // jal x1,+16
    vecs[8] = '{32'h402091B3, ADD,  2'd0, 2'd0, 32'h0,        5'b00001};  // bad funct7 on sll
    vecs[9] = '{32'h0020A423, ADD,  2'd0, 2'd1, 32'h8,        5'b00100};  // sw x2,8(x1)

    rst = 1;
    bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.flush = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 0;

    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].instr, 32'h1000 + 32'(i * 4));
      chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("vec%0d_alu", i), bus.alu_op, vecs[i].alu);
      chk($sformatf("vec%0d_sel", i), {bus.a_sel, bus.b_sel}, {vecs[i].a, vecs[i].b});
      chk($sformatf("vec%0d_imm", i), bus.imm, vecs[i].imm);
      chk($sformatf("vec%0d_flags", i),
          {bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.illegal}, vecs[i].flags);
      chk($sformatf("vec%0d_regs", i), {bus.rs1, bus.rs2, bus.rd},
          {vecs[i].instr[19:15], vecs[i].instr[24:20], vecs[i].instr[11:7]});
      chk($sformatf("vec%0d_pc", i), bus.out_pc, 32'h1000 + 32'(i * 4));
    end

    // stall: outputs hold for 3 cycles while execute is not ready
`ifdef ALU_DEC_SKID_EN
    exp_rdy = 1;
`else
    exp_rdy = 0;
`endif
    xfer(32'h002081B3, 32'h2000);
    bus.out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_bundle", got(), ref_dec(32'h002081B3, 32'h2000));
      chk("stall_in_ready", bus.in_ready, exp_rdy);
    end
    @(negedge clk); bus.out_ready = 1;
    @(posedge clk); #1;
    chk("drain_valid", bus.out_valid, 0);

    // flush discards a same-cycle transfer
    @(negedge clk);
    bus.in_valid = 1; bus.in_instr = 32'h407302B3; bus.in_pc = 32'h2100; bus.flush = 1;
    @(posedge clk); #1;
    bus.in_valid = 0; bus.flush = 0;
    chk("flush_in_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("flush_never_appears", bus.out_valid, 0);

    // flush drops a held bundle
    xfer(32'h407302B3, 32'h2200);
    bus.out_ready = 0;
    @(negedge clk); bus.flush = 1;
    @(posedge clk); #1;
    bus.flush = 0;
    chk("flush_held", bus.out_valid, 0);

    // async reset mid-stream
    xfer(32'h407302B3, 32'h3000);
    bus.out_ready = 0;
    @(negedge clk);
    chk("pre_reset_valid", bus.out_valid, 1);
    rst = 1; #1;
    chk("areset_valid", bus.out_valid, 0);
    chk("areset_alu", bus.alu_op, 0);
    chk("areset_pc", bus.out_pc, 0);
    @(negedge clk); rst = 0;

    // random traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      logic acc, pop;
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = gen_instr();
      bus.in_pc     = $urandom & 32'hFFFF_FFFC;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      #1;
      acc = bus.in_valid && bus.in_ready;
      pop = bus.out_valid && bus.out_ready;
      chk("rnd_valid", bus.out_valid, q.size() != 0);
`ifndef ALU_DEC_SKID_EN
      chk("rnd_in_ready", bus.in_ready, (q.size() == 0) || bus.out_ready);
`endif
      if (pop && q.size() != 0) chk("rnd_bundle", got(), q[0]);
      if (bus.flush) q.delete();
      else begin
        if (pop && q.size() != 0) void'(q.pop_front());
        if (acc) q.push_back(ref_dec(bus.in_instr, bus.in_pc));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
